// File: rtl/conv_enc_pkg.sv
// Shared constants for the rate-1/2, K=3 convolutional encoder frame block.
package conv_enc_pkg;

  // Code definition: constraint length and generator polynomials over {u, s1, s0}.
  localparam int unsigned K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Default widths.
  localparam int unsigned SIZE_DATA_IN  = 8;
  localparam int unsigned SIZE_SYM      = 2;
  localparam int unsigned SIZE_DATA_OUT = SIZE_DATA_IN * SIZE_SYM;
  localparam int unsigned CNT_W         = $clog2(SIZE_DATA_IN);

  // Frame FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ENCODE = 2'd1;
  localparam state_t DONE   = 2'd2;

  // One coded symbol {g0, g1} for input bit u and encoder state {s1, s0}.
  function automatic logic [1:0] conv_sym(input logic u, input logic [K-2:0] st);
    logic [K-1:0] taps;
    taps = {u, st};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder_frame_if.sv
// Frame-level bus of the convolutional encoder. Adds i_err_mask when
// CONV_ERR_INJECT_EN is defined.
interface conv_encoder_frame_if
  import conv_enc_pkg::*;
#(
  parameter int unsigned DataInW  = SIZE_DATA_IN,
  parameter int unsigned SymW     = SIZE_SYM,
  parameter int unsigned DataOutW = SIZE_DATA_OUT
);

  logic                i_start;
  logic [DataInW-1:0]  i_data;
`ifdef CONV_ERR_INJECT_EN
  logic [DataOutW-1:0] i_err_mask;
`endif
  logic [SymW-1:0]     o_sym;
  logic                o_valid;
  logic [DataOutW-1:0] o_word;
  logic                o_busy;
  logic                o_done;

  // Requester side: drives start/payload, observes coded output.
  modport master (
    output i_start,
    output i_data,
`ifdef CONV_ERR_INJECT_EN
    output i_err_mask,
`endif
    input  o_sym,
    input  o_valid,
    input  o_word,
    input  o_busy,
    input  o_done
  );

  // Encoder side.
  modport slave (
    input  i_start,
    input  i_data,
`ifdef CONV_ERR_INJECT_EN
    input  i_err_mask,
`endif
    output o_sym,
    output o_valid,
    output o_word,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/conv_enc_core.sv
// K=3 convolutional encoder core: 2-bit state register plus generator logic.
// o_sym is combinational from the current state and i_bit.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [1:0] o_sym
);

  // {s1, s0}: s1 is the previous bit, s0 the one before it.
  logic [K-2:0] state_q, state_d;

  // Next state: clear wins over shift so a new frame always starts from 00.
  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = '0;
    end else if (i_en) begin
      state_d = {i_bit, state_q[K-2]};
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Generator outputs for the bit being presented.
  always_comb begin
    o_sym = conv_sym(i_bit, state_q);
  end

endmodule

// File: rtl/conv_encoder_frame.sv
// Framed rate-1/2 K=3 convolutional encoder. Latches an 8-bit payload on start,
// emits one registered symbol per cycle MSB first, and assembles the 16-bit
// codeword. Optional error injection (i_err_mask) is enabled by CONV_ERR_INJECT_EN.
module conv_encoder_frame
  import conv_enc_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  conv_encoder_frame_if.slave  bus_io
);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SIZE_DATA_IN-1:0]  shreg_q, shreg_d;
  logic [SIZE_SYM-1:0]      sym_q, sym_d;
  logic                     valid_q, valid_d;
  logic [SIZE_DATA_OUT-1:0] word_q, word_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef CONV_ERR_INJECT_EN
  logic [SIZE_DATA_OUT-1:0] mask_q, mask_d;
`endif

  logic                     accept;
  logic                     enc_en;
  logic [SIZE_SYM-1:0]      enc_sym;

  assign accept = (state_q == IDLE) && bus_io.i_start;
  assign enc_en = (state_q == ENCODE);

  conv_enc_core u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (accept),
    .i_en    (enc_en),
    .i_bit   (shreg_q[SIZE_DATA_IN-1]),
    .o_sym   (enc_sym)
  );

  // Frame FSM, payload shifting and codeword assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    word_d  = word_q;
    done_d  = 1'b0;
`ifdef CONV_ERR_INJECT_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_io.i_start) begin
          state_d = ENCODE;
          cnt_d   = '0;
          shreg_d = bus_io.i_data;
          word_d  = '0;
`ifdef CONV_ERR_INJECT_EN
          mask_d  = bus_io.i_err_mask;
`endif
        end
      end
      ENCODE: begin
`ifdef CONV_ERR_INJECT_EN
        // Mask is consumed from its top two bits, in step with the symbols.
        sym_d  = enc_sym ^ mask_q[SIZE_DATA_OUT-1 -: SIZE_SYM];
        mask_d = {mask_q[SIZE_DATA_OUT-SIZE_SYM-1:0], {SIZE_SYM{1'b0}}};
`else
        sym_d  = enc_sym;
`endif
        valid_d = 1'b1;
        word_d  = {word_q[SIZE_DATA_OUT-SIZE_SYM-1:0], sym_d};
        shreg_d = {shreg_q[SIZE_DATA_IN-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SIZE_DATA_IN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Busy stays up through the done pulse so it covers the whole frame.
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CONV_ERR_INJECT_EN
  // Latched error mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  assign bus_io.o_sym   = sym_q;
  assign bus_io.o_valid = valid_q;
  assign bus_io.o_word  = word_q;
  assign bus_io.o_busy  = busy_q;
  assign bus_io.o_done  = done_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed, table-driven bench for conv_encoder_frame.
module tb_conv_encoder_frame;
  import conv_enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_frame_if bus_if ();

  conv_encoder_frame u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_io  (bus_if)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after T+9.
  task automatic run_frame(input logic [7:0] data, input logic [15:0] exp, input string tag);
    bus_if.i_start = 1'b1;
    bus_if.i_data  = data;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    check({tag, " busy_after_T"}, 32'(bus_if.o_busy), 32'd1);
    check({tag, " valid_after_T"}, 32'(bus_if.o_valid), 32'd0);
    check({tag, " word_cleared"}, 32'(bus_if.o_word), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("%s valid[%0d]", tag, k), 32'(bus_if.o_valid), 32'd1);
      check($sformatf("%s sym[%0d]", tag, k), 32'(bus_if.o_sym), 32'(exp[15-2*k -: 2]));
      check($sformatf("%s no_done[%0d]", tag, k), 32'(bus_if.o_done), 32'd0);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(bus_if.o_done), 32'd1);
    check({tag, " valid_off"}, 32'(bus_if.o_valid), 32'd0);
    check({tag, " busy_T9"}, 32'(bus_if.o_busy), 32'd1);
    check({tag, " word"}, 32'(bus_if.o_word), 32'(exp));
  endtask

  initial begin
    int done_seen;
    bus_if.i_start = 1'b0;
    bus_if.i_data  = 8'h00;
`ifdef CONV_ERR_INJECT_EN
    bus_if.i_err_mask = 16'h0000;
`endif

    vecs[0] = '{data: 8'hA5, word: 16'hE2F8};
    vecs[1] = '{data: 8'h00, word: 16'h0000};
    vecs[2] = '{data: 8'hFF, word: 16'hDAAA};
    vecs[3] = '{data: 8'h80, word: 16'hEC00};
    vecs[4] = '{data: 8'hA5, word: 16'hE2F8};
    vecs[5] = '{data: 8'h40, word: 16'h3B00};
    vecs[6] = '{data: 8'h01, word: 16'h0003};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst sym", 32'(bus_if.o_sym), 32'd0);
    check("rst valid", 32'(bus_if.o_valid), 32'd0);
    check("rst word", 32'(bus_if.o_word), 32'd0);
    check("rst busy", 32'(bus_if.o_busy), 32'd0);
    check("rst done", 32'(bus_if.o_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back frames, each start at T+10 of the previous one.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].word, $sformatf("vec%0d", i));
    end

    // Idle after the last frame: outputs hold, busy/done drop.
    @(negedge clk);
    check("idle busy", 32'(bus_if.o_busy), 32'd0);
    check("idle done", 32'(bus_if.o_done), 32'd0);
    check("idle valid", 32'(bus_if.o_valid), 32'd0);
    check("idle word_hold", 32'(bus_if.o_word), 32'h0003);
    check("idle sym_hold", 32'(bus_if.o_sym), 32'd3);

    // Start held high, payload changed mid-frame.
    bus_if.i_start = 1'b1;
    bus_if.i_data  = 8'hA5;
    @(negedge clk);
    check("hold busy", 32'(bus_if.o_busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("hold sym[%0d]", k), 32'(bus_if.o_sym), 32'(2'(16'hE2F8 >> (14 - 2*k))));
      check($sformatf("hold valid[%0d]", k), 32'(bus_if.o_valid), 32'd1);
      if (k == 2) bus_if.i_data = 8'h00;
    end
    @(negedge clk);
    check("hold done", 32'(bus_if.o_done), 32'd1);
    check("hold word", 32'(bus_if.o_word), 32'hE2F8);
    bus_if.i_data = 8'hFF;
    @(negedge clk);
    // Second frame must be accepted at T+10, not earlier.
    check("hold2 valid_T10", 32'(bus_if.o_valid), 32'd0);
    check("hold2 word_clr", 32'(bus_if.o_word), 32'd0);
    check("hold2 busy", 32'(bus_if.o_busy), 32'd1);
    check("hold2 done_off", 32'(bus_if.o_done), 32'd0);
    bus_if.i_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("hold2 sym[%0d]", k), 32'(bus_if.o_sym), 32'(2'(16'hDAAA >> (14 - 2*k))));
    end
    @(negedge clk);
    check("hold2 done", 32'(bus_if.o_done), 32'd1);
    check("hold2 word", 32'(bus_if.o_word), 32'hDAAA);

    // Reset in the 4th valid cycle aborts the frame.
    @(negedge clk);
    bus_if.i_start = 1'b1;
    bus_if.i_data  = 8'hA5;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("abort valid_before", 32'(bus_if.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort sym", 32'(bus_if.o_sym), 32'd0);
    check("abort valid", 32'(bus_if.o_valid), 32'd0);
    check("abort word", 32'(bus_if.o_word), 32'd0);
    check("abort busy", 32'(bus_if.o_busy), 32'd0);
    check("abort done", 32'(bus_if.o_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus_if.o_done || bus_if.o_valid) done_seen++;
    end
    check("abort no_done_after", 32'(done_seen), 32'd0);
    run_frame(8'hA5, 16'hE2F8, "post_rst");

`ifdef CONV_ERR_INJECT_EN
    @(negedge clk);
    bus_if.i_err_mask = 16'h4001;
    run_frame(8'hA5, 16'hA2F9, "errinj");
    bus_if.i_err_mask = 16'h0000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
